// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller.
//   md_state_e     : mult/div busy-timer states
//   REG_ZERO       : architectural r0, never a real dependency
//   MD_LATENCY_DEF : default mult/div busy latency in cycles
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 32;

endpackage

// File: rtl/hazard_stall_controller_md_busy_timer.sv
// md_busy_timer: tracks the multi-cycle mult/div unit.
//   clk, rst  : core clock, async active-high reset
//   start     : a mult/div is leaving EX this cycle
//   md_busy   : high for exactly MD_LATENCY cycles after start
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic md_busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Counter keeps running through memory freezes: the unit is not stalled.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (start) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_W'(MD_LATENCY);
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - CNT_W'(1);
        if (md_cnt_q == CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: resolves hazards forwarding cannot cover
// (load-use, taken-branch flush, HI/LO interlock, memory freeze) and
// drives the pipeline register enables/flushes.
//   inputs : ID operand info, ID/EX load info, EX branch/mult-div status,
//            MEM request/ready
//   outputs: pc/IF-ID/ID-EX/EX-MEM enables, IF-ID/ID-EX flushes,
//            MEM/WB bubble, md_busy, saturating stall_cycles counter
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_hilo,
  input  logic              id_ex_memread,
  input  logic [4:0]        id_ex_rt,
  input  logic              ex_branch_taken,
  input  logic              ex_md_start,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_bubble,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  logic freeze, lu, hl;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  assign freeze = mem_req & ~mem_ready;
  assign lu     = id_ex_memread & (id_ex_rt != REG_ZERO) &
                  ((id_uses_rs & (id_rs == id_ex_rt)) |
                   (id_uses_rt & (id_rt == id_ex_rt)));
  assign hl     = id_is_hilo & md_busy;

  // A mult/div only starts the timer once it really leaves EX, so a start
  // seen during a freeze is retried on the first unfrozen cycle.
  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (ex_md_start & ex_mem_write),
    .md_busy (md_busy)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (freeze) begin
      // EX is held, so a taken branch waits here and flushes once unfrozen.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // ID holds a wrong-path instruction; its hazards are irrelevant.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu || hl) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != {PERF_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the 5-stage MIPS core. It sits beside the forwarding unit.
- It resolves the hazards that forwarding cannot cover:
  - load-use stalls
  - taken-branch flushes
  - HI/LO interlock against the multi-cycle mult/div unit
  - whole-pipe freeze while data memory is not ready
- It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps a stall performance counter.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit is busy after a mult/div leaves EX (legal range 1..63)
CNT_W, 6, width of the mult/div busy counter (must satisfy 2^CNT_W > MD_LATENCY)
PERF_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  5  ID-stage source register rs
id_rt  in  5  ID-stage source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_hilo  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
id_ex_memread  in  1  ID/EX holds a load
id_ex_rt  in  5  ID/EX load destination register
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_md_start  in  1  EX holds a valid mult/div
mem_req  in  1  MEM stage is performing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_write  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB loads a bubble (RegWrite=0)
md_busy  out  1  mult/div unit busy
stall_cycles  out  PERF_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset: while rst=1, all state clears asynchronously.
  - State is RUN; md_cnt=0; md_busy=0; stall_cycles=0.
  - All write enables and flushes are forced to 0.
  - Reset during MD_BUSY or a memory freeze aborts that activity; there is no residual stall after rst falls.
- State machine (registered) with states RUN and MD_BUSY.
  - RUN -> MD_BUSY when ex_md_start=1 and ex_mem_write=1 (the mult/div actually leaves EX). md_cnt loads MD_LATENCY.
  - In MD_BUSY, md_cnt decrements every cycle, including frozen cycles.
  - MD_BUSY -> RUN when md_cnt reaches 1. md_busy=(state==MD_BUSY), so it is high for exactly MD_LATENCY cycles.
- Control conditions (combinational):
  - freeze = mem_req & ~mem_ready
  - lu = id_ex_memread & (id_ex_rt!=0) & ((id_uses_rs & id_rs==id_ex_rt) | (id_uses_rt & id_rt==id_ex_rt))
  - hl = id_is_hilo & md_busy
- Output priority, highest first; defaults are all write enables 1, all flushes/bubbles 0:
  1. freeze: pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_bubble=1. Flush outputs are 0 even if ex_branch_taken=1. EX is held, so the branch is acted on in the first unfrozen cycle.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1. This overrides lu/hl because the ID instruction is wrong-path.
  3. lu or hl: pc_write=0, if_id_write=0, id_ex_flush=1.
     - A load-use stall lasts exactly 1 cycle.
     - A HI/LO stall lasts until md_busy falls. The ID instruction issues in the cycle md_busy=0.
- A mult/div arriving in ID while md_busy=1 is stalled by hl, so overlapping starts cannot occur.
- stall_cycles increments when pc_write=0 and rst=0, and saturates at all-ones.
- Latency: all outputs except md_busy/stall_cycles are same-cycle combinational from inputs and state. There is no combinational path from any output back to an input.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, MD_BUSY}
  - REG_ZERO=5'd0
  - default MD_LATENCY
- Sub-module md_busy_timer contains md_cnt, the RUN/MD_BUSY FSM and md_busy. The top level contains the priority logic and the perf counter.

Test Plan:
- Load-use: lw r5 in ID/EX (id_ex_memread=1, id_ex_rt=5), ID add with id_rs=5, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle; stall_cycles=1.
- r0 guard: id_ex_rt=0 with id_rs=0 -> no stall, all enables 1.
- Branch versus load-use: ex_branch_taken=1 and lu true in the same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
- HI/LO interlock: MD_LATENCY=4, ex_md_start pulse, then id_is_hilo=1 held -> md_busy high exactly 4 cycles, pc_write=0 for those 4 cycles, released on cycle 5.
- Memory freeze with pending branch: mem_req=1, mem_ready=0 for 3 cycles, ex_branch_taken=1 -> all write enables 0, mem_wb_bubble=1, no flush for 3 cycles; flush asserted on the cycle mem_ready=1.
- Reset mid-operation: assert rst 2 cycles into MD_BUSY -> md_busy=0, stall_cycles=0 immediately (async); after release, id_is_hilo=1 -> no stall.
